// File: rtl/fetch_pair_buffer.sv
// -----------------------------------------------------------------------------
// fetch_pair_buffer
//
// Sits after the convolution address generator. It accepts IFM/filter address
// pairs, issues fixed-latency reads to the IFM and weight SRAMs, and stores the
// returned word pairs in a credit-controlled FIFO. The FIFO feeds the PE array
// over a valid/ready handshake. pe_last marks the final pair of each output
// window so the PEs can clear their accumulators. done_out pulses once the
// read pipeline and the FIFO have fully drained after upstream completion.
//
// Optional feature macro: FETCH_BUF_BYPASS_EN
//   Defined     : when the FIFO is empty, returning SRAM data drives pe_* in
//                 the same cycle. It is written to the FIFO only if the PE
//                 array does not take it in that cycle.
//   Not defined : every pair passes through the FIFO. pe_* come from the
//                 registered FIFO head.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   addr_ifm_in         IFM address from the address generator
//   addr_filter_in      filter address from the address generator
//   addr_valid_in       address pair valid this cycle
//   done_compute_in     upstream completion level; its rising edge starts drain
//   words_per_window    pairs per output window, sampled in IDLE (0 -> 1)
//   addr_stall          no credit this cycle (advisory to upstream)
//   mem_rd_en           read strobe to both SRAMs
//   mem_addr_ifm/filter SRAM read addresses
//   mem_rdata_ifm/filter SRAM read data, valid MEM_LATENCY cycles after strobe
//   pe_valid/pe_ready   output handshake to the PE array
//   pe_data_ifm/filter  output word pair
//   pe_last             pair is the last one of its window
//   fifo_count          occupied FIFO entries
//   overflow            sticky flag: a request was dropped
//   done_out            one-cycle completion pulse
// -----------------------------------------------------------------------------
module fetch_pair_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         addr_ifm_in,
  input  logic [ADDR_WIDTH-1:0]         addr_filter_in,
  input  logic                          addr_valid_in,
  input  logic                          done_compute_in,
  input  logic [15:0]                   words_per_window,
  output logic                          addr_stall,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr_ifm,
  output logic [ADDR_WIDTH-1:0]         mem_addr_filter,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_ifm,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_filter,
  output logic                          pe_valid,
  input  logic                          pe_ready,
  output logic [DATA_WIDTH-1:0]         pe_data_ifm,
  output logic [DATA_WIDTH-1:0]         pe_data_filter,
  output logic                          pe_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          done_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Wide enough for fifo_count plus the largest possible in-flight count.
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Count of set bits in the return-tag shift register.
  function automatic logic [SUM_W-1:0] count_ones(input logic [MEM_LATENCY-1:0] v);
    logic [SUM_W-1:0] acc;
    acc = {SUM_W{1'b0}};
    for (int i = 0; i < MEM_LATENCY; i++) begin
      acc = acc + SUM_W'(v[i]);
    end
    return acc;
  endfunction

  state_t                  state_r;
  state_t                  state_s;
  logic                    done_prev_r;
  logic [15:0]             wpw_r;
  logic [15:0]             win_cnt_r;
  logic                    req_valid_r;
  logic [ADDR_WIDTH-1:0]   req_ifm_r;
  logic [ADDR_WIDTH-1:0]   req_filter_r;
  logic [MEM_LATENCY-1:0]  vsr_r;
  logic [DATA_WIDTH-1:0]   fifo_ifm_r    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   fifo_filter_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    overflow_r;

  logic [SUM_W-1:0]        inflight_s;
  logic                    credit_s;
  logic                    rise_s;
  logic                    accept_s;
  logic                    drop_s;
  logic                    ret_valid_s;
  logic                    fifo_empty_s;
  logic                    byp_s;
  logic                    pop_s;
  logic                    fifo_pop_s;
  logic                    push_s;
  logic                    drain_done_s;

  // In-flight reads are the request stage plus every tagged return slot.
  assign inflight_s   = count_ones(vsr_r) + SUM_W'(req_valid_r);
  assign credit_s     = (SUM_W'(count_r) + inflight_s) < DEPTH_S;
  assign rise_s       = done_compute_in && !done_prev_r;
  assign accept_s     = addr_valid_in && credit_s && (state_r != ST_DRAIN);
  assign drop_s       = addr_valid_in && !accept_s;
  assign ret_valid_s  = vsr_r[MEM_LATENCY-1];
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign drain_done_s = (state_r == ST_DRAIN) && (inflight_s == {SUM_W{1'b0}}) && fifo_empty_s;

`ifdef FETCH_BUF_BYPASS_EN
  assign byp_s = fifo_empty_s && ret_valid_s;
`else
  assign byp_s = 1'b0;
`endif

  assign pop_s      = pe_valid && pe_ready;
  assign fifo_pop_s = pop_s && !fifo_empty_s;
  // A bypassed pair taken by the PEs in its return cycle never enters the FIFO.
  assign push_s     = ret_valid_s && !(byp_s && pe_ready);

  assign addr_stall      = !credit_s;
  assign mem_rd_en       = req_valid_r;
  assign mem_addr_ifm    = req_ifm_r;
  assign mem_addr_filter = req_filter_r;
  assign fifo_count      = count_r;
  assign overflow        = overflow_r;
  assign done_out        = drain_done_s;

  // Output pair selection: bypassed return data, FIFO head, or idle zeros.
  always_comb begin
    pe_valid       = 1'b0;
    pe_data_ifm    = {DATA_WIDTH{1'b0}};
    pe_data_filter = {DATA_WIDTH{1'b0}};
    if (byp_s) begin
      pe_valid       = 1'b1;
      pe_data_ifm    = mem_rdata_ifm;
      pe_data_filter = mem_rdata_filter;
    end else if (!fifo_empty_s) begin
      pe_valid       = 1'b1;
      pe_data_ifm    = fifo_ifm_r[rd_ptr_r];
      pe_data_filter = fifo_filter_r[rd_ptr_r];
    end else begin
      pe_valid       = 1'b0;
    end
    pe_last = pe_valid && (win_cnt_r == (wpw_r - 16'd1));
  end

  // Next-state logic for the IDLE/RUN/DRAIN controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_s = ST_DRAIN;
        end else if (accept_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rise_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Controller state, completion edge detector and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      done_prev_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      done_prev_r <= done_compute_in;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Window length latch and per-window pop counter (both held clear in IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wpw_r     <= 16'd1;
      win_cnt_r <= 16'd0;
    end else if (state_r == ST_IDLE) begin
      wpw_r     <= (words_per_window == 16'd0) ? 16'd1 : words_per_window;
      win_cnt_r <= 16'd0;
    end else if (pop_s) begin
      win_cnt_r <= pe_last ? 16'd0 : (win_cnt_r + 16'd1);
    end
  end

  // Request register driving the SRAM read strobe and addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_r  <= 1'b0;
      req_ifm_r    <= {ADDR_WIDTH{1'b0}};
      req_filter_r <= {ADDR_WIDTH{1'b0}};
    end else if (accept_s) begin
      req_valid_r  <= 1'b1;
      req_ifm_r    <= addr_ifm_in;
      req_filter_r <= addr_filter_in;
    end else begin
      req_valid_r  <= 1'b0;
    end
  end

  // Return-tag shift register; its last stage marks valid SRAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr_r <= {MEM_LATENCY{1'b0}};
    end else begin
      vsr_r[0] <= req_valid_r;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vsr_r[i] <= vsr_r[i-1];
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_ifm_r[i]    <= {DATA_WIDTH{1'b0}};
        fifo_filter_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      fifo_ifm_r[wr_ptr_r]    <= mem_rdata_ifm;
      fifo_filter_r[wr_ptr_r] <= mem_rdata_filter;
    end
  end

  // FIFO pointers (wrap naturally at the power-of-two depth) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (fifo_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, fifo_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pair_buffer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fetch_pair_buffer. An SRAM model returns data derived
// from the read address. A transaction-level reference model checks every
// cycle. It keeps a queue of accepted pairs with their accept cycle, the
// credit rule, the drain/idle mode, the sticky overflow and the window position.
// -----------------------------------------------------------------------------
module tb_fetch_pair_buffer;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int L  = 2;
  localparam int D  = 8;
`ifdef FETCH_BUF_BYPASS_EN
  localparam int FILL = L + 1;
`else
  localparam int FILL = L + 2;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr_ifm_in, addr_filter_in;
  logic          addr_valid_in, done_compute_in;
  logic [15:0]   words_per_window;
  logic          addr_stall, mem_rd_en;
  logic [AW-1:0] mem_addr_ifm, mem_addr_filter;
  logic [DW-1:0] mem_rdata_ifm, mem_rdata_filter;
  logic          pe_valid, pe_ready, pe_last;
  logic [DW-1:0] pe_data_ifm, pe_data_filter;
  logic [3:0]    fifo_count;
  logic          overflow, done_out;

  fetch_pair_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_ifm_in(addr_ifm_in), .addr_filter_in(addr_filter_in),
    .addr_valid_in(addr_valid_in), .done_compute_in(done_compute_in),
    .words_per_window(words_per_window), .addr_stall(addr_stall),
    .mem_rd_en(mem_rd_en), .mem_addr_ifm(mem_addr_ifm), .mem_addr_filter(mem_addr_filter),
    .mem_rdata_ifm(mem_rdata_ifm), .mem_rdata_filter(mem_rdata_filter),
    .pe_valid(pe_valid), .pe_ready(pe_ready),
    .pe_data_ifm(pe_data_ifm), .pe_data_filter(pe_data_filter), .pe_last(pe_last),
    .fifo_count(fifo_count), .overflow(overflow), .done_out(done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ifm_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] filt_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} + 32'h1234_5678;
  endfunction

  // ---------------- SRAM model: fixed latency, junk when not returning -------
  logic          mp_v   [L];
  logic [AW-1:0] mp_ifm [L];
  logic [AW-1:0] mp_fil [L];
  logic [DW-1:0] junk_a, junk_b;

  initial begin
    for (int i = 0; i < L; i++) begin
      mp_v[i] = 1'b0; mp_ifm[i] = '0; mp_fil[i] = '0;
    end
    junk_a = '0; junk_b = '0;
  end

  always @(posedge clk) begin
    mp_v[0]   <= mem_rd_en;
    mp_ifm[0] <= mem_addr_ifm;
    mp_fil[0] <= mem_addr_filter;
    for (int i = 1; i < L; i++) begin
      mp_v[i]   <= mp_v[i-1];
      mp_ifm[i] <= mp_ifm[i-1];
      mp_fil[i] <= mp_fil[i-1];
    end
    junk_a <= $urandom;
    junk_b <= $urandom;
  end

  assign mem_rdata_ifm    = mp_v[L-1] ? ifm_word(mp_ifm[L-1])  : junk_a;
  assign mem_rdata_filter = mp_v[L-1] ? filt_word(mp_fil[L-1]) : junk_b;

  // ---------------- Reference model ----------------
  typedef struct {
    int          acc;
    logic [31:0] a_ifm;
    logic [31:0] a_fil;
  } pair_t;

  pair_t       sbq[$];
  int          cyc = 0;
  bit          m_idle = 1'b1, m_drain = 1'b0, m_ovf = 1'b0, m_done_prev = 1'b0;
  int          m_wpw = 1, m_pops = 0;
  bit          m_rd_prev = 1'b0;
  logic [31:0] m_rd_ifm = '0, m_rd_fil = '0;
  int          done_pulses = 0, obs_pops = 0, obs_lasts = 0;

  always @(negedge clk) begin : model
    bit    credit, exp_done, exp_valid, exp_last, acc_now, pop_now, rise;
    int    fcnt;
    pair_t p;
    if (!rst_n) begin
      sbq.delete();
      m_idle = 1'b1; m_drain = 1'b0; m_ovf = 1'b0; m_done_prev = 1'b0;
      m_wpw = 1; m_pops = 0; m_rd_prev = 1'b0;
    end else begin
      credit    = sbq.size() < D;
      exp_done  = m_drain && (sbq.size() == 0);
      exp_valid = (sbq.size() > 0) && (cyc >= sbq[0].acc + FILL);
      fcnt = 0;
      foreach (sbq[i]) if (sbq[i].acc + L + 2 <= cyc) fcnt++;
      check_eq("addr_stall", addr_stall, !credit);
      check_eq("overflow", overflow, m_ovf);
      check_eq("done_out", done_out, exp_done);
      check_eq("mem_rd_en", mem_rd_en, m_rd_prev);
      if (m_rd_prev) begin
        check_eq("mem_addr_ifm", mem_addr_ifm, m_rd_ifm);
        check_eq("mem_addr_filter", mem_addr_filter, m_rd_fil);
      end
      check_eq("pe_valid", pe_valid, exp_valid);
      check_eq("fifo_count", fifo_count, fcnt);
      if (exp_valid) begin
        exp_last = (m_pops % m_wpw) == (m_wpw - 1);
        check_eq("pe_data_ifm", pe_data_ifm, ifm_word(sbq[0].a_ifm));
        check_eq("pe_data_filter", pe_data_filter, filt_word(sbq[0].a_fil));
        check_eq("pe_last", pe_last, exp_last);
      end else begin
        check_eq("pe_last_idle", pe_last, 1'b0);
      end
      if (done_out) done_pulses++;
      if (pe_valid && pe_ready) begin
        obs_pops++;
        if (pe_last) obs_lasts++;
      end
      // advance the model by one cycle
      acc_now = addr_valid_in && credit && !m_drain;
      pop_now = exp_valid && pe_ready;
      rise    = done_compute_in && !m_done_prev;
      if (m_idle) begin
        m_wpw  = (words_per_window == 16'd0) ? 1 : int'(words_per_window);
        m_pops = 0;
      end
      if (pop_now) begin
        void'(sbq.pop_front());
        m_pops++;
      end
      if (acc_now) begin
        p.acc = cyc; p.a_ifm = addr_ifm_in; p.a_fil = addr_filter_in;
        sbq.push_back(p);
      end
      if (addr_valid_in && !acc_now) m_ovf = 1'b1;
      m_rd_prev = acc_now;
      m_rd_ifm  = addr_ifm_in;
      m_rd_fil  = addr_filter_in;
      if (m_drain) begin
        if (exp_done) begin m_drain = 1'b0; m_idle = 1'b1; end
      end else if (rise) begin
        m_drain = 1'b1; m_idle = 1'b0;
      end else if (m_idle && acc_now) begin
        m_idle = 1'b0;
      end
      m_done_prev = done_compute_in;
    end
    cyc++;
  end

  // ---------------- pe_ready driver ----------------
  int rdy_mode = 0; // 0 low, 1 high, 2 toggle, 3 random
  initial begin
    pe_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       pe_ready = 1'b0;
        1:       pe_ready = 1'b1;
        2:       pe_ready = ~pe_ready;
        default: pe_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  int addr_seq = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_addr();
    addr_ifm_in    = 32'h0001_0000 + 32'(addr_seq) * 32'd4;
    addr_filter_in = $urandom;
    addr_seq++;
  endtask

  // Offer pairs (only when not stalled) until n are accepted.
  task automatic offer_pairs(input int n, input int pct, input bit raise_on_last);
    int got = 0, budget = 0;
    bit v;
    while (got < n && budget < 2000) begin
      v = ($urandom_range(0, 99) < pct) && !addr_stall;
      addr_valid_in = v;
      if (v) set_addr();
      if (v && raise_on_last && got == n - 1) done_compute_in = 1'b1;
      tick();
      if (v) got++;
      budget++;
    end
    addr_valid_in = 1'b0;
    if (got < n) check_eq("offer_timeout", 64'(got), 64'(n));
  endtask

  // Raise completion (unless already raised) and wait for the drain to finish.
  task automatic finish_window(input bit raised, input bit junk_valid);
    int n = 0;
    if (!raised) begin
      done_pulses = 0;
      done_compute_in = 1'b1;
      tick();
    end
    while (m_drain && n < 500) begin
      addr_valid_in = junk_valid ? 1'($urandom_range(0, 1)) : 1'b0;
      if (addr_valid_in) set_addr();
      tick();
      n++;
    end
    addr_valid_in   = 1'b0;
    done_compute_in = 1'b0;
    if (m_drain) check_eq("drain_timeout", 64'd1, 64'd0);
    tick(); tick();
    check_eq("done_once", 64'(done_pulses), 64'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_addr_stall"}, addr_stall, 1'b0);
    check_eq({pfx, "_mem_rd_en"}, mem_rd_en, 1'b0);
    check_eq({pfx, "_mem_addr_ifm"}, mem_addr_ifm, 32'd0);
    check_eq({pfx, "_mem_addr_filter"}, mem_addr_filter, 32'd0);
    check_eq({pfx, "_pe_valid"}, pe_valid, 1'b0);
    check_eq({pfx, "_pe_data_ifm"}, pe_data_ifm, 32'd0);
    check_eq({pfx, "_pe_data_filter"}, pe_data_filter, 32'd0);
    check_eq({pfx, "_pe_last"}, pe_last, 1'b0);
    check_eq({pfx, "_fifo_count"}, fifo_count, 4'd0);
    check_eq({pfx, "_overflow"}, overflow, 1'b0);
    check_eq({pfx, "_done_out"}, done_out, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    addr_valid_in = 1'b0; done_compute_in = 1'b0;
    addr_ifm_in = '0; addr_filter_in = '0; words_per_window = 16'd9;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    tick(); tick(); tick();
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    tick();

    // Streaming: 36 pairs, windows of 9, PE always ready.
    rdy_mode = 1; words_per_window = 16'd9;
    tick();
    obs_pops = 0; obs_lasts = 0;
    offer_pairs(36, 100, 1'b0);
    finish_window(1'b0, 1'b0);
    check_eq("stream_pops", 64'(obs_pops), 64'd36);
    check_eq("stream_lasts", 64'(obs_lasts), 64'd4);

    // Backpressure: PE stalled, requests offered regardless of stall.
    rdy_mode = 0; words_per_window = 16'd3;
    tick();
    for (int i = 0; i < 12; i++) begin
      addr_valid_in = 1'b1; set_addr(); tick();
    end
    addr_valid_in = 1'b0;
    check_eq("bp_fifo_count", fifo_count, 4'd8);
    check_eq("bp_stall", addr_stall, 1'b1);
    check_eq("bp_overflow", overflow, 1'b1);
    rdy_mode = 1;
    finish_window(1'b0, 1'b0);
    check_eq("bp_overflow_sticky", overflow, 1'b1);

    // Hold: pe_ready toggles each cycle; 20 pairs scoreboarded.
    rdy_mode = 2; words_per_window = 16'd5;
    tick();
    obs_pops = 0;
    offer_pairs(20, 70, 1'b0);
    finish_window(1'b0, 1'b0);
    check_eq("hold_pops", 64'(obs_pops), 64'd20);

    // Drain: completion rises with the 12th accept, junk requests after it.
    rdy_mode = 3; words_per_window = 16'd4;
    tick();
    obs_pops = 0; done_pulses = 0;
    offer_pairs(12, 80, 1'b1);
    finish_window(1'b1, 1'b1);
    check_eq("drain_pops", 64'(obs_pops), 64'd12);

    // Random rounds, including words_per_window = 0.
    for (int r = 0; r < 4; r++) begin
      rdy_mode = 3;
      words_per_window = (r == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      tick();
      offer_pairs($urandom_range(5, 25), 60, 1'b0);
      finish_window(1'b0, 1'b1);
    end

    // Reset mid-run: 8 accepts with PE stalled -> 5 in FIFO, 3 in flight.
    rdy_mode = 0; words_per_window = 16'd4;
    tick();
    for (int i = 0; i < 8; i++) begin
      addr_valid_in = 1'b1; set_addr(); tick();
    end
    addr_valid_in = 1'b0;
    check_eq("pre_rst_count", fifo_count, 4'd5);
    check_eq("pre_rst_rd_en", mem_rd_en, 1'b1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("stale_pe_valid", pe_valid, 1'b0);
    end
    check_eq("post_rst_overflow", overflow, 1'b0);

    // Recovery and single-pair latency into an empty FIFO.
    done_pulses = 0;
    offer_pairs(1, 100, 1'b0);
    finish_window(1'b0, 1'b0);
    offer_pairs(10, 90, 1'b0);
    finish_window(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_pair_buffer.md
# fetch_pair_buffer

Downstream stage of the convolution address generator. Takes paired IFM/filter addresses, issues fixed-latency reads to the IFM and weight SRAMs, and buffers the returned word pairs in a credit-controlled FIFO. The FIFO feeds the PE array over a valid/ready handshake and marks window boundaries so the PEs can clear their accumulators. Completion is signalled once the whole read pipeline has drained.

## Interface
- DATA_WIDTH, 32, width of each IFM/filter data word
- ADDR_WIDTH, 32, SRAM address width
- MEM_LATENCY, 2, cycles from `mem_rd_en` to valid `mem_rdata_*` (1..4)
- FIFO_DEPTH, 8, entries; power of two, 4..32

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr_ifm_in  in  ADDR_WIDTH  IFM address from address generator
- addr_filter_in  in  ADDR_WIDTH  filter address from address generator
- addr_valid_in  in  1  address pair valid this cycle
- done_compute_in  in  1  upstream completion level
- words_per_window  in  16  pair count per output window; sampled in IDLE; 0 treated as 1
- addr_stall  out  1  no credit this cycle; advisory to upstream
- mem_rd_en  out  1  read strobe to both SRAMs
- mem_addr_ifm  out  ADDR_WIDTH  IFM SRAM address
- mem_addr_filter  out  ADDR_WIDTH  weight SRAM address
- mem_rdata_ifm  in  DATA_WIDTH  IFM read data
- mem_rdata_filter  in  DATA_WIDTH  weight read data
- pe_valid  out  1  output pair valid
- pe_ready  in  1  PE array accepts pair
- pe_data_ifm  out  DATA_WIDTH  IFM word to PEs
- pe_data_filter  out  DATA_WIDTH  filter word to PEs
- pe_last  out  1  pair is last of its window
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky; a request was dropped
- done_out  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on the first accepted `addr_valid_in`. `words_per_window` is latched in IDLE.
  - RUN -> DRAIN on a 0->1 edge of `done_compute_in`. A request accepted in that same cycle is still processed.
  - DRAIN -> IDLE when in-flight = 0 and `fifo_count` = 0. `done_out` pulses on that transition.
  - If `done_compute_in` rises while in IDLE, go straight to DRAIN.
- Credit: `credit = (fifo_count + inflight) < FIFO_DEPTH`.
  - `inflight` counts the request register stage plus the MEM_LATENCY valid shift register.
  - `addr_stall = !credit`.
- Accept: `addr_valid_in && credit` registers both addresses.
  - `addr_valid_in && !credit` drops the pair and sets `overflow`, which is held until reset.
  - Requests arriving in DRAIN are dropped and set `overflow`.
- Return: a MEM_LATENCY-deep valid shift register tags returning data, which is written into the FIFO as one entry {ifm, filter}.
- Simultaneous FIFO push and pop keeps `fifo_count` unchanged. Credit accounting guarantees a push never finds the FIFO full.
- Window counter: incremented on each pop (`pe_valid && pe_ready`).
  - `pe_last = pe_valid && (win_cnt == words_per_window-1)`.
  - The counter wraps to 0 on the pop that sees `pe_last`.
  - The counter resets to 0 in IDLE.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `addr_stall` 0, `mem_rd_en` 0, `mem_addr_*` 0, `pe_valid` 0, `pe_data_*` 0, `pe_last` 0, `fifo_count` 0, `overflow` 0, `done_out` 0. FSM in IDLE; all counters and pointers 0.
- Request accepted at edge t: `mem_rd_en` and `mem_addr_*` are high/valid during cycle t+1.
- Data sampled at edge t+1+MEM_LATENCY: `pe_valid` high in cycle t+2+MEM_LATENCY. Fill latency is 2+MEM_LATENCY cycles.
- Sustained throughput is one pair per cycle with `pe_ready` held high.
- Holding rule: `pe_data_*` and `pe_last` stay stable while `pe_valid && !pe_ready`.
- Reset asserted mid-operation:
  - All state clears immediately.
  - Returning SRAM data is ignored, because the valid shift register is cleared.
  - No `done_out` is produced.

## Configuration
- `FETCH_BUF_BYPASS_EN` defined: when the FIFO is empty and return data is tagged valid, the pair drives `pe_*` combinationally in the same cycle.
  - If `pe_ready` is high in that cycle, the pair is not written to the FIFO.
  - Fill latency becomes 1+MEM_LATENCY cycles.
- Not defined: every pair passes through the FIFO, and `pe_*` are driven from the registered FIFO head.

## Test plan
- Streaming: 36 consecutive pairs, `words_per_window`=9, `pe_ready`=1, MEM_LATENCY=2.
  - 36 pops in address order, one per cycle.
  - `pe_last` on pops 9, 18, 27, 36.
  - First `pe_valid` 4 cycles after the first accept.
- Backpressure: `pe_ready`=0 with continuous `addr_valid_in`.
  - `addr_stall` rises once `fifo_count` + inflight = 8.
  - The 9th pair offered under stall is dropped and `overflow`=1 (sticky).
- Hold: `pe_ready` toggles every cycle.
  - Outputs are held stable while not accepted.
  - No pair is lost or duplicated; a scoreboard matches all 20 pairs.
- Drain: `done_compute_in` rises in the same cycle as the last (12th) accept.
  - All 12 pairs are delivered.
  - `done_out` pulses exactly once, in the cycle after the final pop empties the pipeline.
- Reset mid-run: `rst_n` low with 3 reads in flight and 5 FIFO entries.
  - All outputs go to their reset values.
  - After release, stale SRAM data never asserts `pe_valid`.
- Bypass (macro on): single pair into an empty FIFO with `pe_ready`=1.
  - `pe_valid` appears 3 cycles after the accept.
  - `fifo_count` stays 0 throughout.
